// File: rtl/display_scan_ctrl_if.sv
// Host/scan-mux bundle for the 4-digit display scan controller.
// The host drives update requests and digit data; the controller drives scan-mux data.
interface display_scan_ctrl_if;
  logic        upd_req;
  logic [15:0] hexs_i;
  logic [3:0]  points_i;
  logic [3:0]  les_i;
  logic [3:0]  blink_i;
  logic [2:0]  bright_i;
  logic        upd_ack;
  logic [1:0]  scan;
  logic [15:0] hexs_o;
  logic [3:0]  points_o;
  logic [3:0]  les_o;
  logic        blank_o;
  logic        frame_o;

  modport master (
    output upd_req, hexs_i, points_i, les_i, blink_i, bright_i,
    input  upd_ack, scan, hexs_o, points_o, les_o, blank_o, frame_o
  );

  modport slave (
    input  upd_req, hexs_i, points_i, les_i, blink_i, bright_i,
    output upd_ack, scan, hexs_o, points_o, les_o, blank_o, frame_o
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment scan sequencer: digit scan index, frame-aligned
// double buffering of host data, per-digit blink and 8-level brightness PWM.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SLOT  = SCAN_DIV / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [1:0]       scan_q,   scan_d;
  logic [FRM_W-1:0] frm_q,    frm_d;
  logic             phase_q,  phase_d;
  logic [15:0]      hexs_q,   hexs_d;
  logic [3:0]       points_q, points_d;
  logic [3:0]       les_sh_q, les_sh_d;
  logic [3:0]       mask_q,   mask_d;
  logic [2:0]       bright_q, bright_d;
  logic [3:0]       les_q,    les_d;
  logic             ack_q,    ack_d;
  logic             frame_q,  frame_d;
  logic             boundary_s;
  logic [31:0]      on_len_s;

  assign boundary_s = (scan_q == 2'd3) && (cnt_q == CNT_LAST);

  // Next-state: slot/scan counting, and all frame-boundary work (load, blink, flags)
  always_comb begin
    cnt_d    = cnt_q;
    scan_d   = scan_q;
    frm_d    = frm_q;
    phase_d  = phase_q;
    hexs_d   = hexs_q;
    points_d = points_q;
    les_sh_d = les_sh_q;
    mask_d   = mask_q;
    bright_d = bright_q;
    les_d    = les_q;
    ack_d    = 1'b0;
    frame_d  = 1'b0;

    if (cnt_q == CNT_LAST) begin
      cnt_d  = CNT_W'(0);
      scan_d = scan_q + 2'd1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end

    if (boundary_s) begin
      frame_d = 1'b1;
      if (frm_q == FRM_LAST) begin
        frm_d   = FRM_W'(0);
        phase_d = ~phase_q;
      end else begin
        frm_d   = frm_q + FRM_W'(1);
      end
      if (bus.upd_req) begin
        hexs_d   = bus.hexs_i;
        points_d = bus.points_i;
        les_sh_d = bus.les_i;
        mask_d   = bus.blink_i;
        bright_d = bus.bright_i;
        ack_d    = 1'b1;
      end else begin
        ack_d    = 1'b0;
      end
      // Effective blanking uses the freshly loaded shadow and the new blink phase
      les_d = les_sh_d | (mask_d & {4{phase_d}});
    end else begin
      les_d = les_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= CNT_W'(0);
      scan_q   <= 2'd0;
      frm_q    <= FRM_W'(0);
      phase_q  <= 1'b0;
      hexs_q   <= 16'h0000;
      points_q <= 4'h0;
      les_sh_q <= 4'hF;
      mask_q   <= 4'h0;
      bright_q <= 3'd7;
      les_q    <= 4'hF;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      scan_q   <= scan_d;
      frm_q    <= frm_d;
      phase_q  <= phase_d;
      hexs_q   <= hexs_d;
      points_q <= points_d;
      les_sh_q <= les_sh_d;
      mask_q   <= mask_d;
      bright_q <= bright_d;
      les_q    <= les_d;
      ack_q    <= ack_d;
      frame_q  <= frame_d;
    end
  end

  // PWM: digit lit for the first (bright+1)/8 of each slot
  assign on_len_s = (32'(bright_q) + 32'd1) * 32'(SLOT);

  assign bus.blank_o  = (32'(cnt_q) >= on_len_s);
  assign bus.scan     = scan_q;
  assign bus.hexs_o   = hexs_q;
  assign bus.points_o = points_q;
  assign bus.les_o    = les_q;
  assign bus.upd_ack  = ack_q;
  assign bus.frame_o  = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a time-indexed reference model
// (scan position, frame number and blink phase derived from cycles since reset).
module tb_display_scan_ctrl;

  localparam int SD    = 8;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;

  logic clk;
  logic rst_n;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int acks     = 0;

  // reference model state
  int          t;
  logic [15:0] m_hexs;
  logic [3:0]  m_pts;
  logic [3:0]  m_les;
  logic [3:0]  m_mask;
  logic [2:0]  m_bright;
  logic        m_ack;
  logic        m_frame;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    m_hexs   = 16'h0000;
    m_pts    = 4'h0;
    m_les    = 4'hF;
    m_mask   = 4'h0;
    m_bright = 3'd7;
    m_ack    = 1'b0;
    m_frame  = 1'b0;
  endtask

  task automatic check_all();
    logic [3:0] ph;
    int frame_no;
    frame_no = t / FRAME;
    ph = (((frame_no / BF) % 2) == 1) ? 4'hF : 4'h0;
    check_eq("scan",    32'(bus.scan),     32'((t / SD) % 4));
    check_eq("hexs",    32'(bus.hexs_o),   32'(m_hexs));
    check_eq("points",  32'(bus.points_o), 32'(m_pts));
    check_eq("les",     32'(bus.les_o),    32'(m_les | (m_mask & ph)));
    check_eq("blank",   32'(bus.blank_o),  ((t % SD) >= (int'(m_bright) + 1) * (SD / 8)) ? 32'd1 : 32'd0);
    check_eq("upd_ack", 32'(bus.upd_ack),  32'(m_ack));
    check_eq("frame",   32'(bus.frame_o),  32'(m_frame));
  endtask

  // one clock: advance model on the edge, check on the falling edge
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      m_ack   = 1'b0;
      m_frame = 1'b0;
      if ((t % FRAME) == FRAME - 1) begin
        m_frame = 1'b1;
        if (bus.upd_req) begin
          m_hexs   = bus.hexs_i;
          m_pts    = bus.points_i;
          m_les    = bus.les_i;
          m_mask   = bus.blink_i;
          m_bright = bus.bright_i;
          m_ack    = 1'b1;
        end
      end
      t++;
    end
    @(negedge clk);
    if (bus.upd_ack) acks++;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l,
                      input logic [3:0] b, input logic [2:0] br);
    bit got;
    got = 1'b0;
    bus.hexs_i   = h;
    bus.points_i = p;
    bus.les_i    = l;
    bus.blink_i  = b;
    bus.bright_i = br;
    bus.upd_req  = 1'b1;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      step();
      got = bus.upd_ack;
    end
    check_eq("load_ack_seen", 32'(got), 32'd1);
    bus.upd_req = 1'b0;
  endtask

  initial begin
    int a0;
    bit got;
    bus.upd_req  = 1'b0;
    bus.hexs_i   = 16'h0;
    bus.points_i = 4'h0;
    bus.les_i    = 4'h0;
    bus.blink_i  = 4'h0;
    bus.bright_i = 3'd7;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;

    // reset hold
    run(3);
    rst_n = 1'b1;
    run(2 * FRAME);

    // update at boundary: raised mid-frame, visible only from next frame start
    while ((t % FRAME) != 12) step();
    bus.hexs_i   = 16'h1234;
    bus.points_i = 4'h5;
    bus.les_i    = 4'h0;
    bus.blink_i  = 4'h0;
    bus.bright_i = 3'd7;
    bus.upd_req  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      step();
      got = bus.upd_ack;
      if (!got) check_eq("hexs_held", 32'(bus.hexs_o), 32'h0);
    end
    check_eq("ack_seen",    32'(got),          32'd1);
    check_eq("ack_scan",    32'(bus.scan),     32'd0);
    check_eq("ack_frame",   32'(bus.frame_o),  32'd1);
    check_eq("ack_hexs",    32'(bus.hexs_o),   32'h1234);
    bus.upd_req = 1'b0;
    step();
    check_eq("ack_one_cyc", 32'(bus.upd_ack),  32'd0);
    a0 = acks;
    run(2 * FRAME);
    check_eq("no_extra_ack", 32'(acks - a0), 32'd0);

    // held request over three frames, data changing each frame
    a0 = acks;
    bus.upd_req = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ((t % FRAME) == 10) bus.hexs_i = 16'($urandom);
      step();
    end
    bus.upd_req = 1'b0;
    check_eq("held_acks", 32'(acks - a0), 32'd3);

    // blink on digit 1
    load(16'hBEEF, 4'h0, 4'h0, 4'b0010, 3'd7);
    run(5 * FRAME);

    // brightness
    load(16'h0F0F, 4'hA, 4'h0, 4'h0, 3'd1);
    run(FRAME);
    load(16'hF0F0, 4'h5, 4'h0, 4'h0, 3'd7);
    run(FRAME);

    // random traffic
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        if ((t % FRAME) == 5) begin
          bus.hexs_i   = 16'($urandom);
          bus.points_i = 4'($urandom);
          bus.les_i    = 4'($urandom);
          bus.blink_i  = 4'($urandom);
          bus.bright_i = 3'($urandom);
          bus.upd_req  = 1'($urandom_range(0, 1));
        end
        step();
      end
    end
    bus.upd_req = 1'b0;

    // reset mid-operation with a pending request
    load(16'h5A5A, 4'hF, 4'h3, 4'h0, 3'd4);
    while ((t % FRAME) != 2 * SD + 5) step();
    check_eq("pre_rst_scan", 32'(bus.scan), 32'd2);
    bus.upd_req = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    a0 = acks;
    run(3);
    check_eq("rst_no_ack", 32'(acks - a0), 32'd0);
    bus.upd_req = 1'b0;
    rst_n = 1'b1;
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
